// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline front end.
package mips_pkg;

  localparam int unsigned PC_W = 32;
  localparam logic [PC_W-1:0] PC_STEP = 32'd4;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    StReq,
    StHold,
    StDrop
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Request/acknowledge instruction-memory port between the fetch stage and memory.
interface fetch_unit_if;
  import mips_pkg::*;

  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_perf.sv
// Saturating fetch/wait cycle counters for the fetch stage, cleared on reset.
module fetch_perf (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_inc,
  input  logic        wait_inc,
  output logic [31:0] fetch_cnt,
  output logic [31:0] wait_cnt
);

  logic [31:0] fetch_q, fetch_d;
  logic [31:0] wait_q, wait_d;

  always_comb begin
    fetch_d = fetch_q;
    wait_d  = wait_q;
    if (fetch_inc && (fetch_q != 32'hFFFF_FFFF)) fetch_d = fetch_q + 32'd1;
    if (wait_inc && (wait_q != 32'hFFFF_FFFF)) wait_d = wait_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_q <= 32'd0;
      wait_q  <= 32'd0;
    end else begin
      fetch_q <= fetch_d;
      wait_q  <= wait_d;
    end
  end

  assign fetch_cnt = fetch_q;
  assign wait_cnt  = wait_q;

endmodule

// File: rtl/fetch_unit.sv
// MIPS instruction-fetch stage: PC, next-PC selection and multi-cycle imem handshake.
// Optional FETCH_PERF_EN adds saturating fetch_cnt/wait_cnt outputs.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stallf,
  input  logic            pcsrcd,
  input  logic [PC_W-1:0] pcbranchd,
  input  logic            jumpd,
  input  logic [PC_W-1:0] jtad,
  fetch_unit_if.master    imem,
  output logic [31:0]     rd,
  output logic [PC_W-1:0] pcp4f,
  output logic [PC_W-1:0] pcf,
  output logic            ivalid
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     fetch_cnt,
  output logic [31:0]     wait_cnt
`endif
);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pcp4_q;
  logic [PC_W-1:0] tgt_q, tgt_d;
  logic [31:0]     buf_q, buf_d;
  logic [PC_W-1:0] npc;
  logic [PC_W-1:0] target;
  logic            redir;

  always_comb begin
    // A stall suppresses any redirect from decode in the same cycle.
    redir  = (jumpd | pcsrcd) & ~stallf;
    target = jumpd ? jtad : pcbranchd;
    npc    = pc_q + PC_STEP;

    state_d        = state_q;
    pc_d           = pc_q;
    tgt_d          = tgt_q;
    buf_d          = buf_q;
    imem.imem_req  = 1'b0;
    imem.imem_addr = pc_q;
    rd             = NOP_INSTR;
    ivalid         = 1'b0;

    case (state_q)
      StReq: begin
        imem.imem_req = 1'b1;
        if (imem.imem_ack) begin
          rd     = imem.imem_rdata;
          ivalid = 1'b1;
          if (redir) begin
            pc_d = target;
          end else if (!stallf) begin
            pc_d = npc;
          end else begin
            buf_d   = imem.imem_rdata;
            state_d = StHold;
          end
        end else if (redir) begin
          tgt_d   = target;
          state_d = StDrop;
        end
      end
      StHold: begin
        rd     = buf_q;
        ivalid = 1'b1;
        if (redir) begin
          pc_d    = target;
          state_d = StReq;
        end else if (!stallf) begin
          pc_d    = npc;
          state_d = StReq;
        end
      end
      StDrop: begin
        // The outstanding request must complete before the PC may move.
        imem.imem_req = 1'b1;
        if (imem.imem_ack) begin
          pc_d    = redir ? target : tgt_q;
          state_d = StReq;
        end else if (redir) begin
          tgt_d = target;
        end
      end
      default: state_d = StReq;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StReq;
      pc_q    <= RESET_PC;
      pcp4_q  <= RESET_PC + PC_STEP;
      tgt_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pcp4_q  <= pc_d + PC_STEP;
      tgt_q   <= tgt_d;
      buf_q   <= buf_d;
    end
  end

  assign pcf   = pc_q;
  assign pcp4f = pcp4_q;

`ifdef FETCH_PERF_EN
  logic fetch_inc;
  logic wait_inc;

  assign fetch_inc = (state_q == StReq) & imem.imem_ack;
  assign wait_inc  = ~ivalid;

  fetch_perf u_perf (
    .clk       (clk),
    .reset     (reset),
    .fetch_inc (fetch_inc),
    .wait_inc  (wait_inc),
    .fetch_cnt (fetch_cnt),
    .wait_cnt  (wait_cnt)
  );
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: main DUT with configurable wait-state memory,
// plus a second instance reset to 32'hFFFF_FFFC to observe PC wrap.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        stallf, pcsrcd, jumpd;
  logic [31:0] pcbranchd, jtad;
  logic [31:0] rd, pcp4f, pcf;
  logic        ivalid;
  int          wait_states;
  int          mem_cnt;

  logic        stallf2, pcsrcd2, jumpd2;
  logic [31:0] pcbranchd2, jtad2;
  logic [31:0] rd2, pcp4f2, pcf2;
  logic        ivalid2;

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt, wait_cnt, fetch_cnt2, wait_cnt2;
`endif

  fetch_unit_if u_if ();
  fetch_unit_if u_if2 ();

  fetch_unit #(.RESET_PC(32'h0000_0000)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .stallf    (stallf),
    .pcsrcd    (pcsrcd),
    .pcbranchd (pcbranchd),
    .jumpd     (jumpd),
    .jtad      (jtad),
    .imem      (u_if.master),
    .rd        (rd),
    .pcp4f     (pcp4f),
    .pcf       (pcf),
    .ivalid    (ivalid)
`ifdef FETCH_PERF_EN
    ,
    .fetch_cnt (fetch_cnt),
    .wait_cnt  (wait_cnt)
`endif
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
    .clk       (clk),
    .reset     (reset),
    .stallf    (stallf2),
    .pcsrcd    (pcsrcd2),
    .pcbranchd (pcbranchd2),
    .jumpd     (jumpd2),
    .jtad      (jtad2),
    .imem      (u_if2.master),
    .rd        (rd2),
    .pcp4f     (pcp4f2),
    .pcf       (pcf2),
    .ivalid    (ivalid2)
`ifdef FETCH_PERF_EN
    ,
    .fetch_cnt (fetch_cnt2),
    .wait_cnt  (wait_cnt2)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h2010_0000 + {2'b00, a[31:2]};
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: ack after wait_states cycles of a held request.
  assign u_if.imem_ack    = u_if.imem_req && (mem_cnt >= wait_states);
  assign u_if.imem_rdata  = u_if.imem_ack ? mem_word(u_if.imem_addr) : 32'hDEAD_BEEF;
  assign u_if2.imem_ack   = u_if2.imem_req;
  assign u_if2.imem_rdata = mem_word(u_if2.imem_addr);

  always @(posedge clk) begin
    if (reset) mem_cnt <= 0;
    else if (u_if.imem_req && !u_if.imem_ack) mem_cnt <= mem_cnt + 1;
    else mem_cnt <= 0;
  end

  typedef struct {
    int          id;
    logic        iv;
    logic [31:0] rd;
    logic        req;
    logic [31:0] addr;
    logic [31:0] pcf;
    logic        wchk;
    logic [31:0] wpcf;
    logic [31:0] wcnt;
  } exp_t;

  exp_t        sb[$];
  int          n_vec;
  int          n_err;
  int          cyc_id;
  logic        wrap_chk;
  logic [31:0] wrap_pcf;
  logic [31:0] wrap_cnt;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check_eq($sformatf("c%0d ivalid", e.id), {31'd0, ivalid}, {31'd0, e.iv});
      check_eq($sformatf("c%0d rd", e.id), rd, e.rd);
      check_eq($sformatf("c%0d imem_req", e.id), {31'd0, u_if.imem_req}, {31'd0, e.req});
      if (e.req) check_eq($sformatf("c%0d imem_addr", e.id), u_if.imem_addr, e.addr);
      check_eq($sformatf("c%0d pcf", e.id), pcf, e.pcf);
      check_eq($sformatf("c%0d pcp4f", e.id), pcp4f, e.pcf + 32'd4);
      if (e.wchk) begin
        check_eq($sformatf("c%0d wrap pcf", e.id), pcf2, e.wpcf);
        check_eq($sformatf("c%0d wrap pcp4f", e.id), pcp4f2, e.wpcf + 32'd4);
        check_eq($sformatf("c%0d wrap imem_addr", e.id), u_if2.imem_addr, e.wpcf);
`ifdef FETCH_PERF_EN
        check_eq($sformatf("c%0d wrap fetch_cnt", e.id), fetch_cnt2, e.wcnt);
`endif
      end
    end
  end

  // Drive one cycle of decode/hazard inputs and push that cycle's expected outputs.
  task automatic cyc(input logic st, input logic jd, input logic [31:0] jt, input logic pd,
                     input logic [31:0] pt, input logic iv, input logic [31:0] erd,
                     input logic ereq, input logic [31:0] eaddr, input logic [31:0] epcf);
    exp_t e;
    stallf    = st;
    jumpd     = jd;
    jtad      = jt;
    pcsrcd    = pd;
    pcbranchd = pt;
    e.id   = cyc_id;
    e.iv   = iv;
    e.rd   = erd;
    e.req  = ereq;
    e.addr = eaddr;
    e.pcf  = epcf;
    e.wchk = wrap_chk;
    e.wpcf = wrap_pcf;
    e.wcnt = wrap_cnt;
    sb.push_back(e);
    wrap_chk = 1'b0;
    cyc_id++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0; n_err = 0; cyc_id = 0;
    wrap_chk = 1'b0; wrap_pcf = '0; wrap_cnt = '0;
    reset = 1'b1; wait_states = 0;
    stallf = 1'b0; jumpd = 1'b0; pcsrcd = 1'b0; jtad = '0; pcbranchd = '0;
    stallf2 = 1'b0; jumpd2 = 1'b0; pcsrcd2 = 1'b0; jtad2 = '0; pcbranchd2 = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Zero-wait memory from reset; wrap instance checked alongside.
    wrap_chk = 1'b1; wrap_pcf = 32'hFFFF_FFFC; wrap_cnt = 32'd0;
    cyc(0, 0, 0, 0, 0, 1, 32'h2010_0000, 1, 32'h00, 32'h00);
    wrap_chk = 1'b1; wrap_pcf = 32'h0000_0000; wrap_cnt = 32'd1;
    cyc(0, 0, 0, 0, 0, 1, 32'h2010_0001, 1, 32'h04, 32'h04);
    cyc(0, 0, 0, 0, 0, 1, 32'h2010_0002, 1, 32'h08, 32'h08);
    cyc(0, 0, 0, 0, 0, 1, 32'h2010_0003, 1, 32'h0C, 32'h0C);
    cyc(0, 0, 0, 0, 0, 1, 32'h2010_0004, 1, 32'h10, 32'h10);

    // Stall for 3 cycles starting at the ack of 32'h2010_0005.
    cyc(1, 0, 0, 0, 0, 1, 32'h2010_0005, 1, 32'h14, 32'h14);
    cyc(1, 0, 0, 0, 0, 1, 32'h2010_0005, 0, 32'h00, 32'h14);
    cyc(1, 0, 0, 0, 0, 1, 32'h2010_0005, 0, 32'h00, 32'h14);
    cyc(0, 0, 0, 0, 0, 1, 32'h2010_0005, 0, 32'h00, 32'h14);

    // Two wait states.
    wait_states = 2;
    cyc(0, 0, 0, 0, 0, 0, 32'h0, 1, 32'h18, 32'h18);
    cyc(0, 0, 0, 0, 0, 0, 32'h0, 1, 32'h18, 32'h18);
    cyc(0, 0, 0, 0, 0, 1, 32'h2010_0006, 1, 32'h18, 32'h18);

    // Branch while outstanding, re-redirected in DROP; data at 0x1C is discarded.
    cyc(0, 0, 0, 1, 32'h80, 0, 32'h0, 1, 32'h1C, 32'h1C);
    cyc(0, 0, 0, 1, 32'h40, 0, 32'h0, 1, 32'h1C, 32'h1C);
    cyc(0, 0, 0, 0, 0, 0, 32'h0, 1, 32'h1C, 32'h1C);

    // Jump beats branch; then the same request with stall has no effect.
    wait_states = 0;
    cyc(0, 1, 32'h100, 1, 32'h80, 1, 32'h2010_0010, 1, 32'h40, 32'h40);
    cyc(1, 1, 32'h100, 1, 32'h80, 1, 32'h2010_0040, 1, 32'h100, 32'h100);
    cyc(1, 1, 32'h100, 1, 32'h80, 1, 32'h2010_0040, 0, 32'h0, 32'h100);
    cyc(0, 0, 0, 0, 0, 1, 32'h2010_0040, 0, 32'h0, 32'h100);
    cyc(0, 0, 0, 0, 0, 1, 32'h2010_0041, 1, 32'h104, 32'h104);

    // Redirect out of HOLD.
    cyc(1, 0, 0, 0, 0, 1, 32'h2010_0042, 1, 32'h108, 32'h108);
    cyc(0, 1, 32'h300, 0, 0, 1, 32'h2010_0042, 0, 32'h0, 32'h108);
    cyc(1, 0, 0, 0, 0, 1, 32'h2010_00C0, 1, 32'h300, 32'h300);

    // Reset taken from HOLD.
    reset = 1'b1;
    stallf = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc(0, 0, 0, 0, 0, 1, 32'h2010_0000, 1, 32'h00, 32'h00);
    cyc(0, 0, 0, 0, 0, 1, 32'h2010_0001, 1, 32'h04, 32'h04);

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the five-stage MIPS pipeline. Holds the PC and computes PC+4 and the next PC, applying branch/jump redirects from decode and stalls from the hazard unit. Drives a request/acknowledge instruction-memory port that may take several cycles per access. Feeds the fetched instruction `rd` and `pcp4f` to the IF/ID register; whenever no valid instruction is available, it substitutes a NOP (32'h0) so that register latches a bubble.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `clk` in 1, pipeline clock; all state updates on the rising edge.
- `reset` in 1, synchronous, active-high.
- `stallf` in 1, hazard-unit hold. The PC must not advance while it is 1.
- `pcsrcd` in 1, branch taken, resolved in decode.
- `pcbranchd` in 32, branch target.
- `jumpd` in 1, jump in decode. Takes priority over `pcsrcd`.
- `jtad` in 32, jump target, already formed as {pcp4[31:28], idx, 2'b00}.
- `imem_req` out 1, memory request.
- `imem_addr` out 32, word address (byte PC, bits [1:0] = 0).
- `imem_ack` in 1, memory done. May be asserted in the same cycle as `imem_req`.
- `imem_rdata` in 32, instruction. Valid only while `imem_ack` = 1.
- `rd` out 32, instruction to the IF/ID register. 0 when not valid.
- `pcp4f` out 32, PC+4 of the current PC.
- `pcf` out 32, current PC.
- `ivalid` out 1, `rd` holds a real instruction this cycle.

## Operation
- States: REQ, HOLD, DROP. Shared registers:
  - `pc` (32)
  - `tgt` (32), pending redirect target
  - `buf` (32), held instruction
- Redirect: `redir = (jumpd | pcsrcd) & ~stallf`. Target is `jtad` if `jumpd`, else `pcbranchd`.
- Next sequential PC: `npc = pc + 4`, modulo 2^32 (wraps from 32'hFFFF_FFFC to 0).
- **REQ**: `imem_req`=1, `imem_addr`=`pc`.
  - ack & redir: `pc`←target; stay REQ. `rd` = `imem_rdata`, `ivalid`=1 (decode flushes it).
  - ack & ~stallf: `pc`←`npc`; stay REQ. `rd` = `imem_rdata`, `ivalid`=1.
  - ack & stallf: `buf`←`imem_rdata`; go HOLD. `rd` = `imem_rdata`, `ivalid`=1.
  - ~ack & redir: `tgt`←target; go DROP. `rd`=0, `ivalid`=0.
  - ~ack otherwise: stay REQ. `rd`=0, `ivalid`=0.
- **HOLD**: `imem_req`=0. `rd`=`buf`, `ivalid`=1; the memory is not re-read.
  - redir: `pc`←target; go REQ.
  - ~stallf: `pc`←`npc`; go REQ.
  - stallf: stay HOLD.
- **DROP**: `imem_req`=1, `imem_addr`=old `pc` (unchanged). `rd`=0, `ivalid`=0.
  - ack: discard data, `pc`←`tgt`; go REQ.
  - A new `redir` while in DROP overwrites `tgt` (last redirect wins).
- Protocol invariant: once `imem_req` is raised, `imem_req` and `imem_addr` stay constant until the cycle `imem_ack` is seen. A request is never retracted.
- `pcp4f` = `pc`+4 in every state.

## Timing
- Reset (any state, any cycle):
  - `pc`=`RESET_PC`, state=REQ, `tgt`=0, `buf`=0.
  - Outputs in the reset cycle are don't-care. The first cycle after `reset` falls has `imem_req`=1 and `imem_addr`=`RESET_PC`.
  - Instruction memory shares this reset, so no ack from a pre-reset request arrives afterwards.
- Zero-wait memory (ack in the same cycle as req): one instruction per cycle, and the PC updates on the same edge.
- N-cycle memory: `rd`=0 for N cycles, then one valid cycle. The PC advances on the ack edge.
- Redirect latency: target appears on `imem_addr` one cycle after `redir` in REQ or HOLD. From DROP, it appears one cycle after the ack.
- `stallf` and `redir` in the same cycle: `stallf` wins (`redir` is gated off).
- Output decode: `rd`, `ivalid`, `imem_req` and `imem_addr` are combinational from state, `imem_ack` and `imem_rdata`. `pcf` and `pcp4f` are registered.

## Configuration
- `FETCH_PERF_EN`
  - Defined: adds two output ports, both 32-bit counters that saturate at 32'hFFFF_FFFF and clear on `reset`:
    - `fetch_cnt` counts cycles with `imem_ack` in REQ.
    - `wait_cnt` counts cycles with `ivalid`=0.
  - Undefined: ports and logic are absent; behaviour is otherwise identical.

## Structure
- Shared package `mips_pkg`:
  - fetch state enum (REQ, HOLD, DROP)
  - `NOP_INSTR` = 32'h0
  - `PC_W` = 32
  - `PC_STEP` = 4
- Sub-module `fetch_perf`: the saturating counter pair, instantiated only under `FETCH_PERF_EN`.
- Next-PC selection stays inline.

## Test plan
- **Reset then zero-wait memory.** Stimulus: `RESET_PC`=0, ack tied to req. Required: `imem_addr` = 0, 4, 8, 12 on consecutive cycles; `pcp4f` = 4, 8, 12, 16; `ivalid` = 1 throughout.
- **Two-wait-state memory.** Stimulus: ack two cycles after req. Required: `rd`=0 for two cycles, then `imem_rdata`; `imem_addr` held stable; `pc` steps 0→4 on the ack edge only.
- **Stall during ack.** Stimulus: `stallf`=1 for 3 cycles starting at an ack of 32'h2010_0005. Required: HOLD; `rd`=32'h2010_0005 for 3 cycles; `imem_req`=0; `pc` unchanged; `pc`+4 on release.
- **Branch while a fetch is outstanding.** Stimulus: `pcsrcd`=1, `pcbranchd`=32'h40 in REQ with no ack. Required: DROP; old address held until ack; that data discarded; next `imem_addr`=32'h40.
- **Jump priority and stall gating.** Stimulus: first `jumpd`=1, `jtad`=32'h100 together with `pcsrcd`=1, `pcbranchd`=32'h80, then the same inputs with `stallf`=1. Required: with `stallf`=0 the PC becomes 32'h100; with `stallf`=1 there is no redirect.
- **PC wrap.** Stimulus: reset with `RESET_PC`=32'hFFFF_FFFC, zero-wait memory. Required: `pcp4f`=0 and next `imem_addr`=0. With `FETCH_PERF_EN`, `fetch_cnt` increments each cycle.
